// File: rtl/cvxif_result_scheduler_if.sv
// Bundle of all CV-X-IF result-scheduler signals: issue allocation, ALU
// result capture, commit/kill, result handshake and occupancy.
interface cvxif_result_scheduler_if #(
  parameter int Depth       = 4,
  parameter int XLEN        = 32,
  parameter int IdWidth     = 4,
  parameter int HartidWidth = 1
);
  logic                     alloc_valid_i;
  logic                     alloc_ready_o;
  logic [IdWidth-1:0]       alloc_id_i;
  logic [HartidWidth-1:0]   alloc_hartid_i;
  logic                     alu_valid_i;
  logic [IdWidth-1:0]       alu_id_i;
  logic [HartidWidth-1:0]   alu_hartid_i;
  logic [4:0]               alu_rd_i;
  logic                     alu_we_i;
  logic [XLEN-1:0]          alu_data_i;
  logic                     commit_valid_i;
  logic [IdWidth-1:0]       commit_id_i;
  logic [HartidWidth-1:0]   commit_hartid_i;
  logic                     commit_kill_i;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [IdWidth-1:0]       result_id_o;
  logic [HartidWidth-1:0]   result_hartid_o;
  logic [4:0]               result_rd_o;
  logic                     result_we_o;
  logic [XLEN-1:0]          result_data_o;
  logic [$clog2(Depth):0]   count_o;

  // Scheduler side
  modport slave (
    input  alloc_valid_i, alloc_id_i, alloc_hartid_i,
    input  alu_valid_i, alu_id_i, alu_hartid_i, alu_rd_i, alu_we_i, alu_data_i,
    input  commit_valid_i, commit_id_i, commit_hartid_i, commit_kill_i,
    input  result_ready_i,
    output alloc_ready_o, result_valid_o, result_id_o, result_hartid_o,
    output result_rd_o, result_we_o, result_data_o, count_o
  );

  // Decoder / ALU / CPU side
  modport master (
    output alloc_valid_i, alloc_id_i, alloc_hartid_i,
    output alu_valid_i, alu_id_i, alu_hartid_i, alu_rd_i, alu_we_i, alu_data_i,
    output commit_valid_i, commit_id_i, commit_hartid_i, commit_kill_i,
    output result_ready_i,
    input  alloc_ready_o, result_valid_o, result_id_o, result_hartid_o,
    input  result_rd_o, result_we_o, result_data_o, count_o
  );
endinterface

// File: rtl/cvxif_result_scheduler.sv
// In-order result buffer between the coprocessor ALU and the CV-X-IF result
// interface. One slot per issued instruction; results are released only
// after data has arrived and the instruction is committed. Killed heads are
// dropped without being offered.
module cvxif_result_scheduler #(
  parameter int Depth       = 4,
  parameter int XLEN        = 32,
  parameter int IdWidth     = 4,
  parameter int HartidWidth = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  cvxif_result_scheduler_if.slave  bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  // Slot control state (reset)
  logic [Depth-1:0]       r_live;
  logic [Depth-1:0]       r_dvalid;
  logic [Depth-1:0]       r_commit;
  logic [Depth-1:0]       r_kill;
  logic [PtrW-1:0]        r_head;
  logic [PtrW-1:0]        r_tail;
  logic [CntW-1:0]        r_count;

  // Slot payload (not reset; qualified by r_live)
  logic [IdWidth-1:0]     r_id     [Depth];
  logic [HartidWidth-1:0] r_hartid [Depth];
  logic [4:0]             r_rd     [Depth];
  logic [Depth-1:0]       r_we;
  logic [XLEN-1:0]        r_data   [Depth];

  logic                   w_alloc;
  logic                   w_pop;
  logic                   w_res_valid;
  logic                   w_head_kill;
  logic [Depth-1:0]       w_alu_hit;
  logic [Depth-1:0]       w_cmt_hit;

  assign bus.alloc_ready_o = (r_count < FullCnt);
  assign w_alloc     = bus.alloc_valid_i && bus.alloc_ready_o;
  assign w_res_valid = r_live[r_head] && r_dvalid[r_head] && r_commit[r_head] && !r_kill[r_head];
  assign w_head_kill = r_live[r_head] && r_kill[r_head];
  assign w_pop       = (w_res_valid && bus.result_ready_i) || w_head_kill;

  // Match ALU results and commit decisions against live slots (old state only,
  // so a slot allocated this cycle never matches)
  always_comb begin
    w_alu_hit = '0;
    w_cmt_hit = '0;
    for (int i = 0; i < Depth; i++) begin
      w_alu_hit[i] = bus.alu_valid_i && r_live[i] && !r_dvalid[i] &&
                     (r_id[i] == bus.alu_id_i) && (r_hartid[i] == bus.alu_hartid_i);
      w_cmt_hit[i] = bus.commit_valid_i && r_live[i] &&
                     (r_id[i] == bus.commit_id_i) && (r_hartid[i] == bus.commit_hartid_i);
    end
  end

  // Slot flags, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_live   <= '0;
      r_dvalid <= '0;
      r_commit <= '0;
      r_kill   <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (w_alu_hit[i]) r_dvalid[i] <= 1'b1;
        if (w_cmt_hit[i]) begin
          if (bus.commit_kill_i) r_kill[i]   <= 1'b1;
          else                   r_commit[i] <= 1'b1;
        end
      end
      if (w_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + PtrW'(1);
      end
      // The tail slot is never live when alloc is accepted, so it cannot
      // collide with the pop or match updates above.
      if (w_alloc) begin
        r_live[r_tail]   <= 1'b1;
        r_dvalid[r_tail] <= 1'b0;
        r_commit[r_tail] <= 1'b0;
        r_kill[r_tail]   <= 1'b0;
        r_tail           <= r_tail + PtrW'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot payload: tag on allocation, result fields on ALU capture
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (w_alu_hit[i]) begin
        r_rd[i]   <= bus.alu_rd_i;
        r_we[i]   <= bus.alu_we_i;
        r_data[i] <= bus.alu_data_i;
      end
    end
    if (w_alloc) begin
      r_id[r_tail]     <= bus.alloc_id_i;
      r_hartid[r_tail] <= bus.alloc_hartid_i;
      r_rd[r_tail]     <= '0;
      r_we[r_tail]     <= 1'b0;
      r_data[r_tail]   <= '0;
    end
  end

  // Result port driven from the head slot, zero when the head is empty
  always_comb begin
    bus.result_valid_o  = w_res_valid;
    bus.result_id_o     = '0;
    bus.result_hartid_o = '0;
    bus.result_rd_o     = '0;
    bus.result_we_o     = 1'b0;
    bus.result_data_o   = '0;
    bus.count_o         = r_count;
    if (r_live[r_head]) begin
      bus.result_id_o     = r_id[r_head];
      bus.result_hartid_o = r_hartid[r_head];
      bus.result_rd_o     = r_rd[r_head];
      bus.result_we_o     = r_we[r_head];
      bus.result_data_o   = r_data[r_head];
    end
  end
endmodule

// File: tb/tb_cvxif_result_scheduler.sv
// Scoreboard bench for cvxif_result_scheduler: stimulus pushes expected
// results; a negedge monitor pops and compares on every handshake.
module tb_cvxif_result_scheduler;
  localparam int Depth = 4;
  localparam int XLEN  = 32;
  localparam int IdW   = 4;
  localparam int HW    = 1;

  typedef struct packed {
    logic [IdW-1:0]  id;
    logic [HW-1:0]   hart;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cvxif_result_scheduler_if #(.Depth(Depth), .XLEN(XLEN), .IdWidth(IdW), .HartidWidth(HW)) vif();

  cvxif_result_scheduler #(.Depth(Depth), .XLEN(XLEN), .IdWidth(IdW), .HartidWidth(HW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (vif)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_act;
  exp_t mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must be the oldest expected one
  always @(negedge clk) begin
    if (rst_n && vif.result_valid_o && vif.result_ready_i) begin
      mon_act = '{id: vif.result_id_o, hart: vif.result_hartid_o, rd: vif.result_rd_o,
                  we: vif.result_we_o, data: vif.result_data_o};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d data 0x%0h, expected none",
                 mon_act.id, mon_act.data);
      end else begin
        mon_exp = sb.pop_front();
        chk("result", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    vif.alloc_valid_i  = 1'b0;
    vif.alu_valid_i    = 1'b0;
    vif.commit_valid_i = 1'b0;
  endtask

  task automatic alloc(input logic [IdW-1:0] id, input logic [HW-1:0] h);
    vif.alloc_valid_i  = 1'b1;
    vif.alloc_id_i     = id;
    vif.alloc_hartid_i = h;
    cyc();
  endtask

  task automatic set_alu(input logic [IdW-1:0] id, input logic [HW-1:0] h, input logic [4:0] rd,
                         input logic we, input logic [XLEN-1:0] d);
    vif.alu_valid_i  = 1'b1;
    vif.alu_id_i     = id;
    vif.alu_hartid_i = h;
    vif.alu_rd_i     = rd;
    vif.alu_we_i     = we;
    vif.alu_data_i   = d;
  endtask

  task automatic alu(input logic [IdW-1:0] id, input logic [HW-1:0] h, input logic [4:0] rd,
                     input logic we, input logic [XLEN-1:0] d);
    set_alu(id, h, rd, we, d);
    cyc();
  endtask

  task automatic set_commit(input logic [IdW-1:0] id, input logic [HW-1:0] h, input logic kill);
    vif.commit_valid_i  = 1'b1;
    vif.commit_id_i     = id;
    vif.commit_hartid_i = h;
    vif.commit_kill_i   = kill;
  endtask

  task automatic commit(input logic [IdW-1:0] id, input logic [HW-1:0] h, input logic kill);
    set_commit(id, h, kill);
    cyc();
  endtask

  task automatic expect_res(input logic [IdW-1:0] id, input logic [HW-1:0] h, input logic [4:0] rd,
                            input logic we, input logic [XLEN-1:0] d);
    sb.push_back('{id: id, hart: h, rd: rd, we: we, data: d});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.alloc_valid_i = 0; vif.alloc_id_i = 0; vif.alloc_hartid_i = 0;
    vif.alu_valid_i = 0; vif.alu_id_i = 0; vif.alu_hartid_i = 0;
    vif.alu_rd_i = 0; vif.alu_we_i = 0; vif.alu_data_i = 0;
    vif.commit_valid_i = 0; vif.commit_id_i = 0; vif.commit_hartid_i = 0; vif.commit_kill_i = 0;
    vif.result_ready_i = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(vif.result_valid_o), 64'd0);
    chk("rst_alloc_ready", 64'(vif.alloc_ready_o), 64'd1);
    chk("rst_count", 64'(vif.count_o), 64'd0);
    chk("rst_data", 64'(vif.result_data_o), 64'd0);
    rst_n = 1'b1;
    cyc();

    // In-order basic
    vif.result_ready_i = 1'b1;
    alloc(4'd1, 1'b0);
    alloc(4'd2, 1'b0);
    chk("basic_count2", 64'(vif.count_o), 64'd2);
    alu(4'd1, 1'b0, 5'd3, 1'b1, 32'hA5);
    alu(4'd2, 1'b0, 5'd4, 1'b1, 32'h5A);
    expect_res(4'd1, 1'b0, 5'd3, 1'b1, 32'hA5);
    commit(4'd1, 1'b0, 1'b0);
    expect_res(4'd2, 1'b0, 5'd4, 1'b1, 32'h5A);
    commit(4'd2, 1'b0, 1'b0);
    drain();
    chk("basic_count0", 64'(vif.count_o), 64'd0);

    // Backpressure: held stable for 5 cycles
    vif.result_ready_i = 1'b0;
    alloc(4'd3, 1'b0);
    alu(4'd3, 1'b0, 5'd5, 1'b0, 32'h1234_5678);
    expect_res(4'd3, 1'b0, 5'd5, 1'b0, 32'h1234_5678);
    commit(4'd3, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(vif.result_valid_o), 64'd1);
      chk("bp_id", 64'(vif.result_id_o), 64'd3);
      chk("bp_data", 64'(vif.result_data_o), 64'h1234_5678);
      cyc();
    end
    vif.result_ready_i = 1'b1;
    cyc();
    chk("bp_count0", 64'(vif.count_o), 64'd0);
    chk("bp_valid0", 64'(vif.result_valid_o), 64'd0);

    // Out-of-order completion
    alloc(4'd4, 1'b0);
    alloc(4'd5, 1'b0);
    alu(4'd5, 1'b0, 5'd6, 1'b1, 32'h55);
    commit(4'd5, 1'b0, 1'b0);
    chk("ooo_hol_block", 64'(vif.result_valid_o), 64'd0);
    alu(4'd4, 1'b0, 5'd7, 1'b1, 32'h44);
    chk("ooo_uncommitted", 64'(vif.result_valid_o), 64'd0);
    expect_res(4'd4, 1'b0, 5'd7, 1'b1, 32'h44);
    expect_res(4'd5, 1'b0, 5'd6, 1'b1, 32'h55);
    commit(4'd4, 1'b0, 1'b0);
    drain();

    // Hart id must participate in matching
    alloc(4'd9, 1'b1);
    alu(4'd9, 1'b0, 5'd1, 1'b1, 32'hBAD);
    commit(4'd9, 1'b0, 1'b1);
    alu(4'd9, 1'b1, 5'd9, 1'b1, 32'h99);
    expect_res(4'd9, 1'b1, 5'd9, 1'b1, 32'h99);
    commit(4'd9, 1'b1, 1'b0);
    drain();

    // Kill before result; late result dropped
    alloc(4'd6, 1'b0);
    commit(4'd6, 1'b0, 1'b1);
    chk("kill_count1", 64'(vif.count_o), 64'd1);
    cyc();
    chk("kill_count0", 64'(vif.count_o), 64'd0);
    cyc();
    alu(4'd6, 1'b0, 5'd2, 1'b1, 32'hDEAD);
    for (int k = 0; k < 3; k++) begin
      chk("kill_no_valid", 64'(vif.result_valid_o), 64'd0);
      cyc();
    end
    chk("kill_count_end", 64'(vif.count_o), 64'd0);

    // Full buffer
    alloc(4'd10, 1'b0);
    alloc(4'd11, 1'b0);
    alloc(4'd12, 1'b0);
    alloc(4'd13, 1'b0);
    chk("full_ready", 64'(vif.alloc_ready_o), 64'd0);
    chk("full_count", 64'(vif.count_o), 64'd4);
    alloc(4'd14, 1'b0);
    chk("full_ignored", 64'(vif.count_o), 64'd4);
    alu(4'd10, 1'b0, 5'd10, 1'b1, 32'hA0A0);
    expect_res(4'd10, 1'b0, 5'd10, 1'b1, 32'hA0A0);
    commit(4'd10, 1'b0, 1'b0);
    chk("full_pop_cycle_ready", 64'(vif.alloc_ready_o), 64'd0);
    cyc();
    chk("full_after_pop_ready", 64'(vif.alloc_ready_o), 64'd1);
    chk("full_after_pop_count", 64'(vif.count_o), 64'd3);
    commit(4'd11, 1'b0, 1'b1);
    commit(4'd12, 1'b0, 1'b1);
    commit(4'd13, 1'b0, 1'b1);
    cyc();
    cyc();
    chk("full_drained", 64'(vif.count_o), 64'd0);

    // Pointer wrap over 10 transactions, pairs completing out of order
    for (int k = 0; k < 5; k++) begin
      logic [IdW-1:0] a, b;
      a = IdW'(2 * k);
      b = IdW'(2 * k + 1);
      alloc(a, 1'b0);
      alloc(b, 1'b0);
      alu(b, 1'b0, 5'(b), k[0], 32'h1000 + 32'(b));
      alu(a, 1'b0, 5'(a), ~k[0], 32'h1000 + 32'(a));
      expect_res(a, 1'b0, 5'(a), ~k[0], 32'h1000 + 32'(a));
      expect_res(b, 1'b0, 5'(b), k[0], 32'h1000 + 32'(b));
      commit(a, 1'b0, 1'b0);
      commit(b, 1'b0, 1'b0);
      drain();
    end
    chk("wrap_count0", 64'(vif.count_o), 64'd0);

    // Commit and ALU result for the head in the same cycle
    vif.result_ready_i = 1'b0;
    alloc(4'd7, 1'b0);
    set_alu(4'd7, 1'b0, 5'd17, 1'b1, 32'hCAFE_F00D);
    set_commit(4'd7, 1'b0, 1'b0);
    expect_res(4'd7, 1'b0, 5'd17, 1'b1, 32'hCAFE_F00D);
    cyc();
    chk("same_cycle_valid", 64'(vif.result_valid_o), 64'd1);
    chk("same_cycle_data", 64'(vif.result_data_o), 64'hCAFE_F00D);
    vif.result_ready_i = 1'b1;
    cyc();
    chk("same_cycle_count0", 64'(vif.count_o), 64'd0);

    // Asynchronous reset with 3 live slots
    vif.result_ready_i = 1'b0;
    alloc(4'd1, 1'b0);
    alloc(4'd2, 1'b0);
    alloc(4'd3, 1'b0);
    alu(4'd1, 1'b0, 5'd1, 1'b1, 32'h1111);
    commit(4'd1, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(vif.result_valid_o), 64'd1);
    chk("pre_rst_count", 64'(vif.count_o), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(vif.result_valid_o), 64'd0);
    chk("async_rst_count", 64'(vif.count_o), 64'd0);
    chk("async_rst_ready", 64'(vif.alloc_ready_o), 64'd1);
    chk("async_rst_data", 64'(vif.result_data_o), 64'd0);
    chk("async_rst_id", 64'(vif.result_id_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vif.result_ready_i = 1'b1;
    cyc();
    cyc();
    chk("post_rst_count", 64'(vif.count_o), 64'd0);
    chk("post_rst_valid", 64'(vif.result_valid_o), 64'd0);

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cvxif_result_scheduler.md
Name: cvxif_result_scheduler

Overview:
- Result buffer and sequencer between the coprocessor ALU and the CV-X-IF result interface.
- Allocates one in-order slot per accepted issue transaction and captures ALU results, which may arrive at any time.
- Applies commit/kill decisions from the commit interface.
- Drives result_valid with a proper valid/ready handshake, so results wait for CPU ready and are never written back before commit.

Parameters:
- Depth, 4, number of buffer slots; power of 2, at least 2.
- XLEN, 32, result data width.
- IdWidth, 4, width of the instruction id.
- HartidWidth, 1, width of the hart id.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- alloc_valid_i  in  1  issue accepted by decoder; request a slot
- alloc_ready_o  out  1  slot available
- alloc_id_i  in  IdWidth  id of the issued instruction
- alloc_hartid_i  in  HartidWidth  hart of the issued instruction
- alu_valid_i  in  1  ALU result strobe (single cycle)
- alu_id_i  in  IdWidth  id of the ALU result
- alu_hartid_i  in  HartidWidth  hart of the ALU result
- alu_rd_i  in  5  destination register
- alu_we_i  in  1  register write enable
- alu_data_i  in  XLEN  result data
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  IdWidth  committed or killed id
- commit_hartid_i  in  HartidWidth  committed or killed hart
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result offered to CPU
- result_ready_i  in  1  CPU accepts result
- result_id_o  out  IdWidth  result id
- result_hartid_o  out  HartidWidth  result hart
- result_rd_o  out  5  result destination register
- result_we_o  out  1  result write enable
- result_data_o  out  XLEN  result data
- count_o  out  $clog2(Depth)+1  occupied slots

Behaviour:
- Slot fields: live, id, hartid, data_valid, committed, killed, rd, we, data.
- FIFO structure: head/tail pointers of $clog2(Depth) bits that wrap modulo Depth, plus a separate count.
- Reset: all slots not live; pointers and count 0. result_valid_o=0, alloc_ready_o=1, count_o=0. All result_* data outputs 0.
- Allocation:
  - alloc_ready_o = (count < Depth), purely combinational; a pop in the same cycle does not free a slot for an alloc in that cycle.
  - When alloc_valid_i && alloc_ready_o, the tail slot becomes live with id/hartid, data_valid=committed=killed=0, and tail increments.
  - alloc_valid_i while full is ignored; the upstream must hold.
- ALU capture:
  - On alu_valid_i, every live slot with matching id and hartid and data_valid=0 latches rd/we/data and sets data_valid.
  - No match means the result is dropped silently (its instruction was already killed and popped).
  - A slot allocated in the same cycle is not matched.
- Commit:
  - On commit_valid_i, every live slot with matching id and hartid sets killed (commit_kill_i=1) or committed (commit_kill_i=0).
  - A commit that matches no live slot is ignored; a slot allocated in the same cycle is not matched.
  - Commit and ALU capture to the same slot in the same cycle both take effect.
- Output:
  - result_valid_o = head.live && head.data_valid && head.committed && !head.killed.
  - result_* fields are driven combinationally from the head slot and are 0 when the head is not live.
  - Once result_valid_o is high, it and all result fields are held stable until result_ready_i, because head fields are immutable after data_valid && committed.
- Pop:
  - Handshake (result_valid_o && result_ready_i) pops the head.
  - A live, killed head is popped automatically in one cycle regardless of data_valid, with result_valid_o=0.
  - At most one pop per cycle.
  - Alloc and pop in the same cycle leave count unchanged.
- Ordering: results leave strictly in allocation order. A non-head slot that is complete waits behind the head (head-of-line by design).
- Protocol requirement: id/hartid pairs are unique among live slots. On violation, all matching slots are updated.
- Reset mid-operation: all slots are discarded immediately (asynchronous) and outputs return to their reset values.

Test Plan:
- In-order basic: alloc ids 1,2; ALU results id1 data 0xA5, id2 data 0x5A; commit 1 then 2; ready=1 -> two results in order, id1/0xA5 then id2/0x5A; count_o returns to 0.
- Backpressure: id3 complete and committed, ready=0 for 5 cycles -> result_valid_o=1 with fields stable for all 5 cycles; pop on the cycle ready rises.
- Out-of-order completion: alloc 4,5; ALU result 5 first, then 4; both committed -> id4 is output before id5; id5 is not offered until id4 pops.
- Kill before result: alloc 6; commit kill 6; ALU result id6 arrives 3 cycles later -> result_valid_o never asserts; count drops to 0 one cycle after the kill; late result is dropped.
- Full: Depth=4, alloc 4 ids with no results -> alloc_ready_o=0, count_o=4; a 5th alloc_valid_i is ignored; after one pop, alloc_ready_o=1 the next cycle; pointers wrap correctly over 10 further transactions.
- Same-cycle events: commit and ALU result for the head in one cycle -> result_valid_o=1 the next cycle. Assert rst_ni mid-stream with 3 live slots -> outputs are 0 immediately and count_o=0.
